// File: rtl/unidade_controle_if.sv
// ---------------------------------------------------------------------------
// unidade_controle_if
//
// Groups the signals between the control unit of the memory-sequence game
// and its datapath.
//
//   Datapath -> control (status flags):
//     iniciar       start request, level-sampled
//     jogada_feita  one-cycle pulse from the datapath edge detector
//     igual         ROM data equals registered play
//     fimRodada     play address equals current round index
//     fimTotal      round index equals mode limit
//     fimT          play timeout counter reached its end
//
//   Control -> datapath (strobes and result flags):
//     zeraCL/contaCL    clear / increment round counter
//     zeraC/contaC      clear / increment play address counter
//                       (zeraC also clears the timer and the edge detector)
//     zeraR/registraR   clear / load play register
//     conta             timeout counter enable
//     pronto            game finished
//     acertou/errou/timeout  result flags, mutually exclusive
//
// Modports: master = control unit, slave = datapath side.
// ---------------------------------------------------------------------------
interface unidade_controle_if;
    logic iniciar;
    logic jogada_feita;
    logic igual;
    logic fimRodada;
    logic fimTotal;
    logic fimT;

    logic zeraCL;
    logic contaCL;
    logic zeraC;
    logic contaC;
    logic zeraR;
    logic registraR;
    logic conta;
    logic pronto;
    logic acertou;
    logic errou;
    logic timeout;

    modport master (
        input  iniciar, jogada_feita, igual, fimRodada, fimTotal, fimT,
        output zeraCL, contaCL, zeraC, contaC, zeraR, registraR,
               conta, pronto, acertou, errou, timeout
    );

    modport slave (
        output iniciar, jogada_feita, igual, fimRodada, fimTotal, fimT,
        input  zeraCL, contaCL, zeraC, contaC, zeraR, registraR,
               conta, pronto, acertou, errou, timeout
    );
endinterface

// File: rtl/unidade_controle.sv
// ---------------------------------------------------------------------------
// unidade_controle
//
// Moore control unit for the memory-sequence game. Sequences rounds and
// plays, driving every counter/register/timer strobe of the datapath, and
// ends each game in final_acertou (win), final_errou (wrong play) or
// final_timeout (play timed out).
//
// Ports:
//   clock      system clock, all state on the rising edge
//   reset      asynchronous, active-high; forces state inicial
//   bus        unidade_controle_if.master: status flags in, strobes out
//   db_estado  current state code (debug)
//
// Handshake: the datapath raises jogada_feita for exactly one cycle per
// play; every strobe here is a single-cycle pulse per state visit except
// conta (held through espera_jogada) and the result flags (held while in a
// final state). All outputs decode from the state register only.
//
// Optional feature macro: TIMEOUT_EN. When defined, espera_jogada enables
// the timeout counter (conta) and fimT leads to final_timeout. When
// undefined, conta and timeout are tied low, fimT is ignored and code 0xD
// is treated as any other undefined code.
// ---------------------------------------------------------------------------
module unidade_controle (
    input  logic                  clock,
    input  logic                  reset,
    unidade_controle_if.master    bus,
    output logic [3:0]            db_estado
);

    typedef enum logic [3:0] {
        st_inicial        = 4'h0,
        st_preparacao     = 4'h1,
        st_inicia_rodada  = 4'h2,
        st_espera_jogada  = 4'h3,
        st_registra       = 4'h4,
        st_comparacao     = 4'h5,
        st_proxima_jogada = 4'h6,
        st_proxima_rodada = 4'h7,
        st_final_acertou  = 4'hA,
        st_final_timeout  = 4'hD,
        st_final_errou    = 4'hE
    } state_t;

    state_t state_q;
    state_t state_d;

`ifndef TIMEOUT_EN
    // fimT has no effect in this build; keep it visibly consumed.
    logic unused_fimT;
    assign unused_fimT = bus.fimT;
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            st_inicial: begin
                if (bus.iniciar) state_d = st_preparacao;
            end
            st_preparacao:    state_d = st_inicia_rodada;
            st_inicia_rodada: state_d = st_espera_jogada;
            st_espera_jogada: begin
                // A play arriving together with the timeout still counts.
                if (bus.jogada_feita) begin
                    state_d = st_registra;
                end
`ifdef TIMEOUT_EN
                else if (bus.fimT) begin
                    state_d = st_final_timeout;
                end
`endif
            end
            st_registra:   state_d = st_comparacao;
            st_comparacao: begin
                if (!bus.igual)          state_d = st_final_errou;
                else if (!bus.fimRodada) state_d = st_proxima_jogada;
                else if (!bus.fimTotal)  state_d = st_proxima_rodada;
                else                     state_d = st_final_acertou;
            end
            st_proxima_jogada: state_d = st_espera_jogada;
            st_proxima_rodada: state_d = st_inicia_rodada;
`ifdef TIMEOUT_EN
            st_final_acertou, st_final_errou, st_final_timeout: begin
`else
            st_final_acertou, st_final_errou: begin
`endif
                if (bus.iniciar) state_d = st_preparacao;
            end
            default: state_d = st_inicial;
        endcase
    end

    // Moore output decode
    always_comb begin
        bus.zeraCL    = 1'b0;
        bus.contaCL   = 1'b0;
        bus.zeraC     = 1'b0;
        bus.contaC    = 1'b0;
        bus.zeraR     = 1'b0;
        bus.registraR = 1'b0;
        bus.conta     = 1'b0;
        bus.pronto    = 1'b0;
        bus.acertou   = 1'b0;
        bus.errou     = 1'b0;
        bus.timeout   = 1'b0;
        case (state_q)
            st_preparacao: begin
                bus.zeraCL = 1'b1;
                bus.zeraC  = 1'b1;
                bus.zeraR  = 1'b1;
            end
            st_inicia_rodada: begin
                bus.zeraC = 1'b1;
                bus.zeraR = 1'b1;
            end
`ifdef TIMEOUT_EN
            st_espera_jogada:  bus.conta     = 1'b1;
`endif
            st_registra:       bus.registraR = 1'b1;
            st_proxima_jogada: bus.contaC    = 1'b1;
            st_proxima_rodada: bus.contaCL   = 1'b1;
            st_final_acertou: begin
                bus.pronto  = 1'b1;
                bus.acertou = 1'b1;
            end
            st_final_errou: begin
                bus.pronto = 1'b1;
                bus.errou  = 1'b1;
            end
`ifdef TIMEOUT_EN
            st_final_timeout: begin
                bus.pronto  = 1'b1;
                bus.timeout = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= st_inicial;
        else       state_q <= state_d;
    end

    assign db_estado = state_q;

endmodule
